apb4_rng: RTL and testbench
===========================

// Module: apb4_rng
// PURPOSE
//  APB4 slave peripheral providing 32-bit pseudo-random numbers from a maximal-length LFSR.
//  Software enables the generator, optionally writes a seed, and reads the current value.
//  Sits on the SoC APB4 peripheral bus; zero-wait-state, no interrupts.
// PARAMETERS
//  APB_ADDR_WIDTH  32  width of paddr; only paddr[3:2] is decoded.
//  APB_DATA_WIDTH  32  width of pwdata/prdata; fixed at 32.
//  DEF_SEED        32'h0000_0001  reset value of the LFSR; also substituted for a written seed of 0.
// PORTS
//  clk_i    in   1   APB clock (pclk).
//  rst_n_i  in   1   asynchronous active-low reset (presetn).
//  paddr    in   32  byte address.
//  pprot    in   3   ignored.
//  psel     in   1   slave select.
//  penable  in   1   access phase.
//  pwrite   in   1   1=write, 0=read.
//  pwdata   in   32  write data.
//  pstrb    in   4   byte write strobes.
//  pready   out  1   tied 1; no wait states.
//  prdata   out  32  read data.
//  pslverr  out  1   tied 0.
// BEHAVIOUR
//  Reset (async, rst_n_i=0): CTRL=0, SEED=DEF_SEED, LFSR=DEF_SEED, prdata=0.
//  Access: write commits on the clk_i rising edge with psel&penable&pwrite. The read is
//    combinational, prdata = mux(paddr[3:2]) while psel&!pwrite; otherwise prdata=0.
//  Register map (word offsets):
//    0x00 CTRL  RW  [0] EN (1=LFSR steps every cycle); [31:1] reserved, read 0.
//    0x04 SEED  RW  the written value is stored per pstrb byte lane; the write also loads the LFSR.
//    0x08 VAL   RO  current LFSR state; writes ignored.
//    0x0C+      unmapped: reads 0, writes ignored, pslverr stays 0.
//  LFSR: 32-bit Fibonacci, fb = l[31]^l[21]^l[1]^l[0]; next = {l[30:0], fb}.
//  Step: on each clock with EN=1 and no SEED write, LFSR <= next.
//  SEED write: LFSR <= merged seed (byte lanes from pstrb, others from the old SEED reg).
//    If the merged seed == 0, LFSR <= DEF_SEED instead. The SEED reg holds the written value.
//    A SEED write wins over a same-cycle step.
//  Simultaneous write of CTRL.EN=1: stepping starts the cycle after the write.
//  A VAL read returns the pre-edge state; the state may advance on the same edge.
//  EN=0: LFSR holds its value; VAL reads are stable.
//  All-zero LFSR state is unreachable (seed-0 substitution guarantees this).
//  Reset mid-operation returns all state to reset values immediately, independent of the clock.
// TESTING
//  1 Reset: release rst_n_i -> read CTRL=0, SEED=1, VAL=1, pready=1, pslverr=0.
//  2 Write SEED=1 with EN=0, then write CTRL=1, then clear EN after 3 steps
//    -> VAL sequence 0x1,0x3,0x6,0xD; VAL holds 0xD.
//  3 Write SEED=0 -> SEED reads 0 and VAL reads 0x1 (DEF_SEED substituted).
//  4 Write SEED=0xFFFF_FFFF with pstrb=4'b0001 over old SEED 0x1 -> SEED=0x000000FF, VAL=0xFF.
//  5 EN=1 free-running for 1000 cycles -> VAL never 0 and changes every read.
//    Then EN=0 -> two consecutive reads are equal.
//  6 Read 0x0C and write 0x08 -> read 0, VAL unaffected by the write, pslverr=0.
//    Assert rst_n_i mid-run -> VAL=1 asynchronously.

Source files
------------

// File: rtl/apb4_rng.sv
// APB4 pseudo-random number peripheral: CTRL/SEED/VAL registers around a 32-bit
// maximal-length Fibonacci LFSR. Zero wait states, never signals an error.
module apb4_rng #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter logic [31:0] DEF_SEED       = 32'h0000_0001
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]                pprot,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]                pstrb,
  output logic                      pready,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pslverr
);

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_SEED = 2'd1;
  localparam logic [1:0] ADDR_VAL  = 2'd2;

  logic        r_en;
  logic [31:0] r_seed;
  logic [31:0] r_lfsr;

  logic [1:0]  w_word;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_seed;
  logic [31:0] w_seed_merged;
  logic [31:0] w_lfsr_next;
  logic        w_unused;

  assign w_word    = paddr[3:2];
  assign w_wr      = psel & penable & pwrite;
  assign w_wr_ctrl = w_wr && (w_word == ADDR_CTRL);
  assign w_wr_seed = w_wr && (w_word == ADDR_SEED);
  assign w_unused  = ^{pprot, paddr[APB_ADDR_WIDTH-1:4], paddr[1:0]};

  assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

  // Byte lanes not strobed keep the previous SEED contents
  always_comb begin
    w_seed_merged = r_seed;
    for (int i = 0; i < 4; i++) begin
      if (pstrb[i]) w_seed_merged[8*i +: 8] = pwdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_en   <= 1'b0;
      r_seed <= DEF_SEED;
      r_lfsr <= DEF_SEED;
    end else begin
      if (w_wr_ctrl && pstrb[0]) r_en <= pwdata[0];
      // A seed load overrides a same-cycle step; zero would lock the LFSR
      if (w_wr_seed) begin
        r_seed <= w_seed_merged;
        r_lfsr <= (w_seed_merged == 32'd0) ? DEF_SEED : w_seed_merged;
      end else if (r_en) begin
        r_lfsr <= w_lfsr_next;
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (w_word)
        ADDR_CTRL: prdata = APB_DATA_WIDTH'({31'd0, r_en});
        ADDR_SEED: prdata = APB_DATA_WIDTH'(r_seed);
        ADDR_VAL:  prdata = APB_DATA_WIDTH'(r_lfsr);
        default:   prdata = '0;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = 1'b0;

endmodule

// File: tb/tb_apb4_rng.sv
// Directed bench for apb4_rng: vector table for register access, hand sequences
// for stepping, enable timing, free-running and asynchronous reset.
module tb_apb4_rng;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] paddr = '0;
  logic [2:0]  pprot = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  apb4_rng dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge clk_i); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk_i); #1;
    penable = 1'b1;
    @(posedge clk_i); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    #1;
    data = prdata;
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] m;
    logic [31:0] prev;
    logic [31:0] rd2;

    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h4, 0, 0, 32'h1));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'h1));
    vecs.push_back(mk(0, 32'hC, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h4, 32'h0, 4'hF, 0));
    vecs.push_back(mk(0, 32'h4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'h1));
    vecs.push_back(mk(1, 32'h4, 32'h1, 4'hF, 0));
    vecs.push_back(mk(1, 32'h4, 32'hFFFF_FFFF, 4'b0001, 0));
    vecs.push_back(mk(0, 32'h4, 0, 0, 32'h0000_00FF));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'h0000_00FF));
    vecs.push_back(mk(1, 32'h8, 32'h1234_5678, 4'hF, 0));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'h0000_00FF));
    vecs.push_back(mk(0, 32'hC, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'hC, 32'hDEAD_BEEF, 4'hF, 0));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'h0000_00FF));
    vecs.push_back(mk(1, 32'h0, 32'hFFFF_FFFE, 4'hF, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h4, 32'hA5A5_0000, 4'b1100, 0));
    vecs.push_back(mk(0, 32'h4, 0, 0, 32'hA5A5_00FF));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'hA5A5_00FF));
    vecs.push_back(mk(1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 0));
    vecs.push_back(mk(0, 32'h4, 0, 0, 32'hA5A5_00FF));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'hA5A5_00FF));
    vecs.push_back(mk(1, 32'h0, 32'h0000_0001, 4'b0000, 0));
    vecs.push_back(mk(0, 32'h8, 0, 0, 32'hA5A5_00FF));

    #12 rst_n_i = 1'b1;

    // Register access table (EN stays 0 throughout)
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        @(posedge clk_i); #1;
        apb_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rd@%0h", i, vecs[i].addr), rd, vecs[i].exp);
        check($sformatf("vec%0d_pready", i), 32'(pready), 32'h1);
        check($sformatf("vec%0d_pslverr", i), 32'(pslverr), 32'h0);
        psel = 1'b0;
      end
    end

    // Step sequence 1,3,6,D with EN cleared on the third step edge
    apb_write(32'h4, 32'h1, 4'hF);
    apb_write(32'h0, 32'h1, 4'hF);
    apb_read(32'h8, rd); check("seq_v0", rd, 32'h1);
    @(posedge clk_i); #1; check("seq_v1", prdata, 32'h3);
    @(posedge clk_i); #1; check("seq_v2", prdata, 32'h6);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk_i); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(32'h8, rd); check("seq_v3", rd, 32'hD);
    @(posedge clk_i); #1; check("seq_hold", prdata, 32'hD);
    apb_read(32'h0, rd); check("seq_en_off", rd, 32'h0);
    psel = 1'b0;

    // Free-running against a reference LFSR
    apb_write(32'h4, 32'h0000_ACE1, 4'hF);
    apb_write(32'h0, 32'h1, 4'hF);
    m = 32'h0000_ACE1;
    apb_read(32'h8, rd); check("run_start", rd, m);
    for (int n = 0; n < 1000; n++) begin
      prev = prdata;
      @(posedge clk_i); #1;
      m = lfsr_next(m);
      check($sformatf("run%0d_val", n), prdata, m);
      if (prdata == 32'h0) check($sformatf("run%0d_nonzero", n), prdata, 32'h1);
      if (prdata == prev) check($sformatf("run%0d_changed", n), prdata, ~prev);
    end
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk_i); #1;
    m = lfsr_next(m);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(32'h8, rd); check("stop_val", rd, m);
    @(posedge clk_i); #1; rd2 = prdata;
    check("stop_stable", rd2, rd);
    psel = 1'b0;

    // Seed write wins over a same-cycle step
    apb_write(32'h0, 32'h1, 4'hF);
    apb_write(32'h4, 32'h0000_0055, 4'hF);
    apb_read(32'h8, rd); check("seed_wins", rd, 32'h55);
    @(posedge clk_i); #1; check("seed_then_step", prdata, lfsr_next(32'h55));

    // Asynchronous reset mid-cycle while running
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1; check("arst_val", prdata, 32'h1);
    apb_read(32'h0, rd); check("arst_ctrl", rd, 32'h0);
    apb_read(32'h4, rd); check("arst_seed", rd, 32'h1);
    @(posedge clk_i); #1; apb_read(32'h8, rd); check("arst_hold", rd, 32'h1);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1; apb_read(32'h8, rd); check("post_rst_idle", rd, 32'h1);
    psel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
